// File: rtl/addsub_pkg.sv
// Shared types and helpers for the segmented add/sub pipeline.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helpers can describe.
    localparam int MAX_W = 64;

    // Per-stage side-band payload that travels alongside the operand and sum vectors.
    typedef struct packed {
        logic carry;     // carry into the next segment
        logic add_ctrl;  // OP_ADD / OP_SUB
        logic sat;       // clamp on signed overflow
        logic a_sign;    // A[msb]
        logic b_sign;    // msb of the B actually added (B or ~B)
    } stage_meta_t;

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One pipeline stage: resolves segment IDX of the sum and registers it with the carry.
module addsub_seg
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    input  stage_meta_t      i_meta,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_sum,
    output stage_meta_t      o_meta
);

    localparam int LO = IDX * SEG_W;

    logic [SEG_W:0]     w_seg_sum;
    logic               r_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    stage_meta_t        r_meta;

    assign w_seg_sum = {1'b0, i_a[LO +: SEG_W]} + {1'b0, i_b[LO +: SEG_W]}
                     + (SEG_W + 1)'(i_meta.carry);

    // NOTE: the data fields are reset as well as the valid bit so the flag outputs read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_meta  <= '0;
        end else if (i_en) begin
            r_valid           <= i_valid;
            r_a               <= i_a;
            r_a[LO +: SEG_W]  <= '0;
            r_b               <= i_b;
            r_b[LO +: SEG_W]  <= '0;
            r_sum             <= i_sum;
            r_sum[LO +: SEG_W] <= w_seg_sum[SEG_W-1:0];
            r_meta            <= i_meta;
            r_meta.carry      <= w_seg_sum[SEG_W];
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_meta  = r_meta;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub: SEGS carry-registered segments, valid/ready on both sides,
// flags and optional signed saturation after the last stage. WIDTH must be a multiple of SEGS.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_ctrl,
    input  logic             Sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             O,
    output logic             Z
);

    localparam int SEG_W = WIDTH / SEGS;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    logic                w_adv;
    logic [SEGS:0]       w_valid;
    logic [WIDTH-1:0]    w_a   [SEGS+1];
    logic [WIDTH-1:0]    w_b   [SEGS+1];
    logic [WIDTH-1:0]    w_sum [SEGS+1];
    stage_meta_t         w_meta [SEGS+1];
    logic [WIDTH-1:0]    w_raw;
    stage_meta_t         w_last;
    logic                w_ovf;
    logic                w_unused_ops;

    // Whole pipeline moves as one; a held output freezes every stage behind it.
    assign w_adv    = !w_valid[SEGS] || out_ready;
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_a[0]     = A;
    assign w_b[0]     = (Add_ctrl == OP_SUB) ? ~B : B;
    assign w_sum[0]   = '0;
    assign w_meta[0]  = '{carry:    Add_ctrl,
                          add_ctrl: Add_ctrl,
                          sat:      Sat,
                          a_sign:   A[WIDTH-1],
                          b_sign:   w_b[0][WIDTH-1]};

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        addsub_seg #(
            .WIDTH (WIDTH),
            .SEG_W (SEG_W),
            .IDX   (k)
        ) u_seg (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_valid (w_valid[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_sum   (w_sum[k]),
            .i_meta  (w_meta[k]),
            .o_valid (w_valid[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_sum   (w_sum[k+1]),
            .o_meta  (w_meta[k+1])
        );
    end

    // Every operand segment has been consumed by the last stage.
    assign w_unused_ops = ^{w_a[SEGS], w_b[SEGS]};

    assign w_raw  = w_sum[SEGS];
    assign w_last = w_meta[SEGS];

    // With B already inverted for subtract, one same-sign rule covers both operations.
    assign w_ovf = (w_last.a_sign == w_last.b_sign) && (w_raw[WIDTH-1] != w_last.a_sign);

    assign out_valid = w_valid[SEGS];
    assign C_out     = (w_last.add_ctrl == OP_SUB) ? ~w_last.carry : w_last.carry;
    assign O         = w_ovf;
    assign SUM       = (w_last.sat && w_ovf) ? (w_last.a_sign ? SAT_MIN : SAT_MAX) : w_raw;
    assign Z         = out_valid && (SUM == '0);

endmodule
